// File: rtl/proj_extender_assembler.sv
// proj_extender_assembler
//   Reassembles FRAG_PART-wide slices (part 0 first, part 0 in the LSBs) into a
//   FRAG_LEN_BITS fragment and tags it with the signed start index latched from
//   the sop slice. The fragment is presented on a valid/ready output register.
//   A new sop while a fragment is partially collected aborts it and bumps a
//   saturating drop counter. An index that differs between slices of one
//   fragment sets out_err.
//   Optional feature: define PROJ_ASSEMBLER_CLIP_EN to clip negative start
//   indices. The index is forced to 0 and the leading 2*|index| bits (2 bits
//   per base) are zeroed. A magnitude of FRAG_LEN_BITS/2 or more zeroes the
//   whole fragment.
module proj_extender_assembler #(
    parameter int FRAG_LEN_BITS     = 32,
    parameter int FRAG_PART         = 8,
    parameter int SIGNED_INDICE_LEN = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sop,
    input  logic [FRAG_PART-1:0]         in_gfm,
    input  logic [SIGNED_INDICE_LEN-1:0] in_index,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FRAG_LEN_BITS-1:0]     out_fragment,
    output logic [SIGNED_INDICE_LEN-1:0] out_index,
    output logic                         out_err,
    output logic [7:0]                   out_drop_cnt
);

    localparam int PARTS = FRAG_LEN_BITS / FRAG_PART;
    localparam int CNT_W = $clog2(PARTS);
    localparam logic [CNT_W-1:0] LAST_PART = CNT_W'(PARTS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                         state_reg;
    state_t                         state_next;
    logic [CNT_W-1:0]               part_cnt_reg;
    logic [FRAG_LEN_BITS-1:0]       asm_reg;
    logic [FRAG_LEN_BITS-1:0]       asm_next;
    logic [SIGNED_INDICE_LEN-1:0]   idx_reg;
    logic                           err_reg;
    logic [7:0]                     drop_cnt_reg;

    logic                           out_valid_reg;
    logic [FRAG_LEN_BITS-1:0]       out_fragment_reg;
    logic [SIGNED_INDICE_LEN-1:0]   out_index_reg;
    logic                           out_err_reg;

    logic                           accept;
    logic                           last_slice;
    logic                           frag_done;
    logic                           abort;
    logic                           idx_mismatch;
    logic [FRAG_LEN_BITS-1:0]       frag_final;
    logic [SIGNED_INDICE_LEN-1:0]   index_final;

    assign accept       = in_valid & in_ready;
    // Waiting for the final slice: completing it requires a free output register
    assign last_slice   = (state_reg == COLLECT) && (part_cnt_reg == LAST_PART);
    assign frag_done    = accept & ~in_sop & last_slice;
    assign abort        = accept & in_sop & (state_reg == COLLECT);
    assign idx_mismatch = (in_index != idx_reg);

    // Slice write: an sop slice goes to part 0, otherwise to the current part
    // while collecting. Slices seen in IDLE without sop write nothing.
    generate
        for (genvar gi = 0; gi < PARTS; gi++) begin : g_slice
            localparam bit IS_FIRST = (gi == 0);
            logic wr;
            assign wr = accept & (in_sop ? IS_FIRST
                                         : ((state_reg == COLLECT) && (part_cnt_reg == CNT_W'(gi))));
            assign asm_next[gi*FRAG_PART +: FRAG_PART] =
                wr ? in_gfm : asm_reg[gi*FRAG_PART +: FRAG_PART];
        end
    endgenerate

`ifdef PROJ_ASSEMBLER_CLIP_EN
    logic                           idx_neg;
    logic [SIGNED_INDICE_LEN:0]     neg_mag;
    logic [FRAG_LEN_BITS-1:0]       clip_keep;

    assign idx_neg = idx_reg[SIGNED_INDICE_LEN-1];
    assign neg_mag = -{idx_reg[SIGNED_INDICE_LEN-1], idx_reg};

    // Bit gi belongs to base gi/2; keep it only if that base is at or past the
    // clipped start. A large magnitude therefore clears every bit.
    generate
        for (genvar gi = 0; gi < FRAG_LEN_BITS; gi++) begin : g_clip
            assign clip_keep[gi] = ~idx_neg | (neg_mag <= (SIGNED_INDICE_LEN+1)'(gi / 2));
        end
    endgenerate

    assign frag_final  = asm_next & clip_keep;
    assign index_final = idx_neg ? '0 : idx_reg;
`else
    assign frag_final  = asm_next;
    assign index_final = idx_reg;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: sop always (re)starts collection, final slice returns to IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && in_sop) state_next = COLLECT;
            end
            COLLECT: begin
                if (frag_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM output: stall only the final slice while the output register is still occupied
    always_comb begin
        in_ready = 1'b1;
        if (last_slice && out_valid_reg && !out_ready) in_ready = 1'b0;
    end

    // Collection datapath: slice buffer, part counter, latched index and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_reg      <= '0;
            part_cnt_reg <= '0;
            idx_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            asm_reg <= asm_next;
            if (accept && in_sop) begin
                part_cnt_reg <= CNT_W'(1);
                idx_reg      <= in_index;
                err_reg      <= 1'b0;
            end else if (accept && (state_reg == COLLECT)) begin
                part_cnt_reg <= part_cnt_reg + CNT_W'(1);
                if (idx_mismatch) err_reg <= 1'b1;
            end
        end
    end

    // Saturating count of partial fragments aborted by a fresh sop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (abort && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    // Output register: load on completion (even while being consumed), else clear on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg    <= 1'b0;
            out_fragment_reg <= '0;
            out_index_reg    <= '0;
            out_err_reg      <= 1'b0;
        end else if (frag_done) begin
            out_valid_reg    <= 1'b1;
            out_fragment_reg <= frag_final;
            out_index_reg    <= index_final;
            out_err_reg      <= err_reg | idx_mismatch;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg    <= 1'b0;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_fragment = out_fragment_reg;
    assign out_index    = out_index_reg;
    assign out_err      = out_err_reg;
    assign out_drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_proj_extender_assembler.sv
// Testbench for proj_extender_assembler (32-bit fragments, 8-bit slices, 16-bit index).
// Table of single-cycle slice vectors with out_ready=1, then hand sequences for
// output backpressure and asynchronous reset in the middle of a fragment.
module tb_proj_extender_assembler;

`ifdef PROJ_ASSEMBLER_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic [7:0]  in_gfm;
    logic [15:0] in_index;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_fragment;
    logic [15:0] out_index;
    logic        out_err;
    logic [7:0]  out_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    proj_extender_assembler #(
        .FRAG_LEN_BITS     (32),
        .FRAG_PART         (8),
        .SIGNED_INDICE_LEN (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sop       (in_sop),
        .in_gfm       (in_gfm),
        .in_index     (in_index),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_fragment (out_fragment),
        .out_index    (out_index),
        .out_err      (out_err),
        .out_drop_cnt (out_drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [15:0] i;
        logic        eov;
        logic [31:0] ef;
        logic [15:0] ei;
        logic        ee;
        logic [7:0]  ed;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addv(input logic v, input logic s, input logic [7:0] d, input logic [15:0] i,
                        input logic eov, input logic [31:0] ef, input logic [15:0] ei,
                        input logic ee, input logic [7:0] ed);
        vq.push_back('{v, s, d, i, eov, ef, ei, ee, ed});
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic [15:0] i);
        in_valid = v;
        in_sop   = s;
        in_gfm   = d;
        in_index = i;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- vector table (out_ready held at 1) ----------------
        // test 1: plain fragment, then out_valid drops one cycle later
        addv(1, 1, 8'h11, 16'd100, 0, 32'h0, 16'h0, 0, 8'd0);
        addv(1, 0, 8'h22, 16'd100, 0, 32'h0, 16'h0, 0, 8'd0);
        addv(1, 0, 8'h33, 16'd100, 0, 32'h0, 16'h0, 0, 8'd0);
        addv(1, 0, 8'h44, 16'd100, 1, 32'h44332211, 16'd100, 0, 8'd0);
        addv(0, 0, 8'h00, 16'd0,   0, 32'h0, 16'h0, 0, 8'd0);
        // test 3: aborted partial fragment
        addv(1, 1, 8'hAA, 16'd5, 0, 32'h0, 16'h0, 0, 8'd0);
        addv(1, 0, 8'hBB, 16'd5, 0, 32'h0, 16'h0, 0, 8'd0);
        addv(1, 1, 8'h01, 16'd5, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'h02, 16'd5, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'h03, 16'd5, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'h04, 16'd5, 1, 32'h04030201, 16'd5, 0, 8'd1);
        // test 4: stray slice in IDLE ignored, index mismatch flagged
        addv(1, 0, 8'h99, 16'd7, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 1, 8'hA0, 16'd7, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hA1, 16'd7, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hA2, 16'd8, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hA3, 16'd7, 1, 32'hA3A2A1A0, 16'd7, 1, 8'd1);
        // negative index -3, back-to-back with the next fragment
        addv(1, 1, 8'hB0, 16'hFFFD, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hB1, 16'hFFFD, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hB2, 16'hFFFD, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hB3, 16'hFFFD, 1, CLIP ? 32'hB3B2B180 : 32'hB3B2B1B0,
             CLIP ? 16'h0 : 16'hFFFD, 0, 8'd1);
        addv(1, 1, 8'hC0, 16'd0, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hC1, 16'd0, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hC2, 16'd0, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hC3, 16'd0, 1, 32'hC3C2C1C0, 16'd0, 0, 8'd1);
        // test 6: index -2 on all-ones data
        addv(1, 1, 8'hFF, 16'hFFFE, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hFF, 16'hFFFE, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hFF, 16'hFFFE, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'hFF, 16'hFFFE, 1, CLIP ? 32'hFFFFFFF0 : 32'hFFFFFFFF,
             CLIP ? 16'h0 : 16'hFFFE, 0, 8'd1);
        // index -16: magnitude reaches FRAG_LEN_BITS/2
        addv(1, 1, 8'h5A, 16'hFFF0, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'h5A, 16'hFFF0, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'h5A, 16'hFFF0, 0, 32'h0, 16'h0, 0, 8'd1);
        addv(1, 0, 8'h5A, 16'hFFF0, 1, CLIP ? 32'h0 : 32'h5A5A5A5A,
             CLIP ? 16'h0 : 16'hFFF0, 0, 8'd1);
        addv(0, 0, 8'h00, 16'd0, 0, 32'h0, 16'h0, 0, 8'd1);

        // ---------------- reset ----------------
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(0, 0, 8'h00, 16'h0);
        #3;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_fragment", out_fragment, 32'h0);
        chk("reset out_index", 32'(out_index), 32'h0);
        chk("reset out_err", 32'(out_err), 32'h0);
        chk("reset out_drop_cnt", 32'(out_drop_cnt), 32'h0);
        #9;
        rst_n = 1'b1;
        step();
        chk("in_ready after reset", 32'(in_ready), 32'h1);
        $display("reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);

        // ---------------- table run ----------------
        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].v, vq[k].s, vq[k].d, vq[k].i);
            step();
            $display("row %0d: v=%0b sop=%0b d=%h idx=%h -> out_valid=%0b frag=%h idx=%h err=%0b drop=%0d",
                     k, vq[k].v, vq[k].s, vq[k].d, vq[k].i, out_valid, out_fragment, out_index,
                     out_err, out_drop_cnt);
            chk($sformatf("row%0d out_valid", k), 32'(out_valid), 32'(vq[k].eov));
            chk($sformatf("row%0d out_drop_cnt", k), 32'(out_drop_cnt), 32'(vq[k].ed));
            if (vq[k].eov) begin
                chk($sformatf("row%0d out_fragment", k), out_fragment, vq[k].ef);
                chk($sformatf("row%0d out_index", k), 32'(out_index), 32'(vq[k].ei));
                chk($sformatf("row%0d out_err", k), 32'(out_err), 32'(vq[k].ee));
            end
        end

        // ---------------- test 2: backpressure ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1, k == 0, 8'hD0 + 8'(k), 16'd1);
            step();
        end
        chk("bp frag1 out_valid", 32'(out_valid), 32'h1);
        chk("bp frag1 data", out_fragment, 32'hD3D2D1D0);
        for (int k = 0; k < 3; k++) begin
            drive(1, k == 0, 8'hE0 + 8'(k), 16'd2);
            #1;
            chk($sformatf("bp in_ready slice%0d", k), 32'(in_ready), 32'h1);
            @(posedge clk);
            #1;
        end
        drive(1, 0, 8'hE3, 16'd2);
        #1;
        chk("bp in_ready last slice stalled", 32'(in_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp stall%0d in_ready", k), 32'(in_ready), 32'h0);
            chk($sformatf("bp stall%0d held data", k), out_fragment, 32'hD3D2D1D0);
            chk($sformatf("bp stall%0d held index", k), 32'(out_index), 32'd1);
            chk($sformatf("bp stall%0d out_valid", k), 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready on out_ready", 32'(in_ready), 32'h1);
        step();
        drive(0, 0, 8'h00, 16'h0);
        $display("bp: frag2 out_valid=%0b frag=%h idx=%h", out_valid, out_fragment, out_index);
        chk("bp frag2 out_valid", 32'(out_valid), 32'h1);
        chk("bp frag2 data", out_fragment, 32'hE3E2E1E0);
        chk("bp frag2 index", 32'(out_index), 32'd2);
        step();
        chk("bp drained out_valid", 32'(out_valid), 32'h0);

        // ---------------- test 5: reset mid-fragment ----------------
        drive(1, 1, 8'hF0, 16'd3);
        step();
        drive(1, 0, 8'hF1, 16'd3);
        step();
        drive(0, 0, 8'h00, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        $display("mid reset: out_valid=%0b frag=%h drop=%0d", out_valid, out_fragment, out_drop_cnt);
        chk("midrst out_valid", 32'(out_valid), 32'h0);
        chk("midrst out_fragment", out_fragment, 32'h0);
        chk("midrst out_index", 32'(out_index), 32'h0);
        chk("midrst out_drop_cnt", 32'(out_drop_cnt), 32'h0);
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            drive(1, k == 0, 8'h10 * 8'(k + 1), 16'd3);
            step();
        end
        drive(0, 0, 8'h00, 16'h0);
        $display("post reset frag: out_valid=%0b frag=%h idx=%h drop=%0d",
                 out_valid, out_fragment, out_index, out_drop_cnt);
        chk("postrst out_valid", 32'(out_valid), 32'h1);
        chk("postrst out_fragment", out_fragment, 32'h40302010);
        chk("postrst out_index", 32'(out_index), 32'd3);
        chk("postrst out_err", 32'(out_err), 32'h0);
        chk("postrst out_drop_cnt", 32'(out_drop_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
